// File: rtl/axis_tlp_rr_arbiter.sv
// axis_tlp_rr_arbiter
// Round-robin arbiter that shares one AXIS TLP ingest port among PORTS
// requesters. The grant is held for a whole packet, packets longer than
// MAX_PKT_WORDS beats are cut (last forwarded beat marked with tlast and
// tuser[0]) and their remainder is swallowed.
// Optional build macro: TLP_ARB_STATS_EN adds per-port completed-packet
// counters on pkt_count_o.

module axis_tlp_rr_arbiter #(
    parameter int PORTS         = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int USER_WIDTH    = 1,
    parameter int MAX_PKT_WORDS = 69
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [PORTS*KEEP_WIDTH-1:0]   s_axis_tkeep,
    input  logic [PORTS-1:0]              s_axis_tvalid,
    input  logic [PORTS-1:0]              s_axis_tlast,
    input  logic [PORTS*USER_WIDTH-1:0]   s_axis_tuser,
    output logic [PORTS-1:0]              s_axis_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    output logic [USER_WIDTH-1:0]         m_axis_tuser,
    input  logic                          m_axis_tready,
    output logic [PORTS-1:0]              grant_o,
    output logic                          oversize_err_o,
    output logic [$clog2(PORTS)-1:0]      oversize_port_o
`ifdef TLP_ARB_STATS_EN
    ,
    output logic [PORTS*16-1:0]           pkt_count_o
`endif
);

    localparam int PTR_W = $clog2(PORTS);
    localparam int CNT_W = $clog2(MAX_PKT_WORDS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_PKT_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PASS,
        ST_DROP
    } state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    grant_q, grant_d;
    logic [PTR_W-1:0]    rrPtr_q, rrPtr_d;
    logic [CNT_W-1:0]    wordCnt_q, wordCnt_d;
    logic                oversizeErr_q, oversizeErr_d;
    logic [PTR_W-1:0]    oversizePort_q, oversizePort_d;

    logic [DATA_WIDTH-1:0] selData;
    logic [KEEP_WIDTH-1:0] selKeep;
    logic                  selValid;
    logic                  selLast;
    logic [USER_WIDTH-1:0] selUser;
    logic [PORTS-1:0]      grantOneHot;

    logic                  pickValid;
    logic [PTR_W-1:0]      pickIdx;
    logic [PTR_W-1:0]      nextPtr;
    logic                  truncBeat;
    logic                  completePkt;

    // Select the granted requester's beat and build the one-hot grant vector
    always_comb begin
        selData     = '0;
        selKeep     = '0;
        selValid    = 1'b0;
        selLast     = 1'b0;
        selUser     = '0;
        grantOneHot = '0;
        for (int p = 0; p < PORTS; p++) begin
            if (grant_q == PTR_W'(p)) begin
                grantOneHot[p] = 1'b1;
                selData        = s_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH];
                selKeep        = s_axis_tkeep[p*KEEP_WIDTH +: KEEP_WIDTH];
                selValid       = s_axis_tvalid[p];
                selLast        = s_axis_tlast[p];
                selUser        = s_axis_tuser[p*USER_WIDTH +: USER_WIDTH];
            end
        end
    end

    // Find the first valid requester at or after the round-robin pointer;
    // scanning from the far end lets the smallest offset win
    always_comb begin
        logic [PTR_W:0] cand;
        pickValid = 1'b0;
        pickIdx   = '0;
        cand      = '0;
        for (int i = PORTS - 1; i >= 0; i--) begin
            cand = {1'b0, rrPtr_q} + (PTR_W + 1)'(i);
            if (cand >= (PTR_W + 1)'(PORTS)) begin
                cand = cand - (PTR_W + 1)'(PORTS);
            end
            if (s_axis_tvalid[cand[PTR_W-1:0]]) begin
                pickValid = 1'b1;
                pickIdx   = cand[PTR_W-1:0];
            end
        end
    end

    assign nextPtr = (grant_q == PTR_W'(PORTS - 1)) ? '0 : grant_q + PTR_W'(1);

    // Next-state logic for the arbitration FSM plus the handshake signals it owns
    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        rrPtr_d        = rrPtr_q;
        wordCnt_d      = wordCnt_q;
        oversizeErr_d  = 1'b0;
        oversizePort_d = oversizePort_q;
        m_axis_tvalid  = 1'b0;
        s_axis_tready  = '0;
        truncBeat      = 1'b0;
        completePkt    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pickValid) begin
                    grant_d = pickIdx;
                    state_d = ST_PASS;
                end
            end
            ST_PASS: begin
                m_axis_tvalid = selValid;
                s_axis_tready = grantOneHot & {PORTS{m_axis_tready}};
                truncBeat     = (wordCnt_q == CNT_LAST) && !selLast;
                if (selValid && m_axis_tready) begin
                    wordCnt_d = wordCnt_q + CNT_W'(1);
                    if (selLast) begin
                        rrPtr_d     = nextPtr;
                        wordCnt_d   = '0;
                        completePkt = 1'b1;
                        state_d     = ST_IDLE;
                    end else if (truncBeat) begin
                        oversizeErr_d  = 1'b1;
                        oversizePort_d = grant_q;
                        state_d        = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                s_axis_tready = grantOneHot;
                if (selValid && selLast) begin
                    rrPtr_d     = nextPtr;
                    wordCnt_d   = '0;
                    completePkt = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and bookkeeping registers; reset abandons any packet in flight
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_IDLE;
            grant_q        <= '0;
            rrPtr_q        <= '0;
            wordCnt_q      <= '0;
            oversizeErr_q  <= 1'b0;
            oversizePort_q <= '0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            rrPtr_q        <= rrPtr_d;
            wordCnt_q      <= wordCnt_d;
            oversizeErr_q  <= oversizeErr_d;
            oversizePort_q <= oversizePort_d;
        end
    end

    // Forward the granted beat; a cut beat is forced to close the packet and carry the error mark
    always_comb begin
        m_axis_tdata    = selData;
        m_axis_tkeep    = selKeep;
        m_axis_tlast    = selLast | truncBeat;
        m_axis_tuser    = selUser;
        m_axis_tuser[0] = selUser[0] | truncBeat;
    end

    assign grant_o         = (state_q == ST_IDLE) ? '0 : grantOneHot;
    assign oversize_err_o  = oversizeErr_q;
    assign oversize_port_o = oversizePort_q;

`ifdef TLP_ARB_STATS_EN
    logic [15:0] pktCount_q [PORTS];

    // Saturating per-port count of packets whose source tlast was accepted
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int p = 0; p < PORTS; p++) begin
                pktCount_q[p] <= '0;
            end
        end else if (completePkt) begin
            for (int p = 0; p < PORTS; p++) begin
                if (grant_q == PTR_W'(p) && pktCount_q[p] != 16'hFFFF) begin
                    pktCount_q[p] <= pktCount_q[p] + 16'd1;
                end
            end
        end
    end

    // Flatten the counters onto the output bus, port p in slice p
    always_comb begin
        pkt_count_o = '0;
        for (int p = 0; p < PORTS; p++) begin
            pkt_count_o[p*16 +: 16] = pktCount_q[p];
        end
    end
`endif

endmodule

// File: tb/tb_axis_tlp_rr_arbiter.sv
// Testbench for axis_tlp_rr_arbiter: directed packets on the requester
// ports with a queue-based source per port and a capture queue on m_axis.
// Build with TLP_ARB_STATS_EN defined to also exercise pkt_count_o.

module tb_axis_tlp_rr_arbiter;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic        user;
    } beat_t;

    logic          clk;
    logic          rstN;
    logic [127:0]  sData;
    logic [15:0]   sKeep;
    logic [3:0]    sValid;
    logic [3:0]    sLast;
    logic [3:0]    sUser;
    logic [3:0]    sReady;
    logic [31:0]   mData;
    logic [3:0]    mKeep;
    logic          mValid;
    logic          mLast;
    logic [0:0]    mUser;
    logic          mReady;
    logic [3:0]    grant;
    logic          ovErr;
    logic [1:0]    ovPort;
`ifdef TLP_ARB_STATS_EN
    logic [63:0]   pktCount;
`endif

    beat_t       srcQ [4][$];
    beat_t       outQ [$];
    logic [3:0]  outGrant [$];
    int          outCycle [$];
    int          popCount [4];
    int          errPulses;
    int          cycleCnt;
    logic        stallPrev;
    logic [31:0] stallData;
    int          nCompared;
    int          nMismatched;

    axis_tlp_rr_arbiter dut (
        .clk_i           (clk),
        .rst_ni          (rstN),
        .s_axis_tdata    (sData),
        .s_axis_tkeep    (sKeep),
        .s_axis_tvalid   (sValid),
        .s_axis_tlast    (sLast),
        .s_axis_tuser    (sUser),
        .s_axis_tready   (sReady),
        .m_axis_tdata    (mData),
        .m_axis_tkeep    (mKeep),
        .m_axis_tvalid   (mValid),
        .m_axis_tlast    (mLast),
        .m_axis_tuser    (mUser),
        .m_axis_tready   (mReady),
        .grant_o         (grant),
        .oversize_err_o  (ovErr),
        .oversize_port_o (ovPort)
`ifdef TLP_ARB_STATS_EN
        ,
        .pkt_count_o     (pktCount)
`endif
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count a comparison and report it if observed differs from expected
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] expData(input int port, input int pkt, input int beat);
        return {port[7:0], pkt[7:0], beat[15:0]};
    endfunction

    // Queue one packet of nBeats on a port, tlast on the final beat
    task automatic applyStimulus(input int port, input int pkt, input int nBeats);
        beat_t b;
        for (int k = 0; k < nBeats; k++) begin
            b.data = expData(port, pkt, k);
            b.last = (k == nBeats - 1);
            b.user = 1'b0;
            srcQ[port].push_back(b);
        end
    endtask

    // Present the head of each source queue on its port
    task automatic driveInputs();
        for (int p = 0; p < 4; p++) begin
            if (srcQ[p].size() > 0) begin
                sValid[p]          = 1'b1;
                sData[p*32 +: 32]  = srcQ[p][0].data;
                sLast[p]           = srcQ[p][0].last;
                sUser[p]           = srcQ[p][0].user;
                sKeep[p*4 +: 4]    = 4'hF;
            end else begin
                sValid[p]          = 1'b0;
                sData[p*32 +: 32]  = '0;
                sLast[p]           = 1'b0;
                sUser[p]           = 1'b0;
                sKeep[p*4 +: 4]    = 4'h0;
            end
        end
    endtask

    function automatic bit allEmpty();
        int total = 0;
        for (int p = 0; p < 4; p++) total += srcQ[p].size();
        return (total == 0);
    endfunction

    // One clock: observe at the falling edge, advance sources just after the rising edge
    task automatic stepCycle();
        logic [3:0] hs;
        beat_t      b;
        @(negedge clk);
        hs = sValid & sReady;
        if (stallPrev) begin
            checkOutput("stallHoldData", mData, stallData);
            checkOutput("stallHoldValid", mValid, 1);
        end
        stallPrev = mValid & ~mReady;
        stallData = mData;
        if (mValid) checkOutput("readyMirror", sReady, grant & {4{mReady}});
        if (mValid && mReady) begin
            b.data = mData;
            b.last = mLast;
            b.user = mUser[0];
            outQ.push_back(b);
            outGrant.push_back(grant);
            outCycle.push_back(cycleCnt);
        end
        if (ovErr) errPulses++;
        @(posedge clk);
        #1;
        cycleCnt++;
        for (int p = 0; p < 4; p++) begin
            if (hs[p]) begin
                b = srcQ[p].pop_front();
                popCount[p]++;
            end
        end
        driveInputs();
    endtask

    // Step until every source has drained and the arbiter is idle again
    task automatic runToIdle(input int budget);
        int n = 0;
        do begin
            stepCycle();
            n++;
        end while (!(allEmpty() && grant == 4'b0) && n < budget);
        checkOutput("idleReached", (allEmpty() && grant == 4'b0), 1);
    endtask

    task automatic doReset();
        rstN = 1'b0;
        mReady = 1'b1;
        for (int p = 0; p < 4; p++) begin
            srcQ[p].delete();
            popCount[p] = 0;
        end
        outQ.delete();
        outGrant.delete();
        outCycle.delete();
        errPulses = 0;
        stallPrev = 1'b0;
        driveInputs();
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
        cycleCnt = 0;
    endtask

    // Directed scenarios
    initial begin
        nCompared   = 0;
        nMismatched = 0;
        sData = '0; sKeep = '0; sValid = '0; sLast = '0; sUser = '0;
        mReady = 1'b1;
        rstN = 1'b0;
        stallPrev = 1'b0;
        stallData = '0;

        // Single 3-beat packet on port 0
        doReset();
        checkOutput("rstGrant", grant, 0);
        checkOutput("rstSReady", sReady, 0);
        checkOutput("rstMValid", mValid, 0);
        checkOutput("rstOvErr", ovErr, 0);
        checkOutput("rstOvPort", ovPort, 0);
        applyStimulus(0, 1, 3);
        driveInputs();
        stepCycle();
        checkOutput("t1Grant", grant, 4'b0001);
        runToIdle(20);
        checkOutput("t1Count", outQ.size(), 3);
        for (int k = 0; k < 3 && k < outQ.size(); k++) begin
            checkOutput("t1Data", outQ[k].data, expData(0, 1, k));
            checkOutput("t1Last", outQ[k].last, (k == 2));
        end
        checkOutput("t1GrantAfter", grant, 0);

        // All four ports hold a 4-beat packet at once
        doReset();
        for (int p = 0; p < 4; p++) applyStimulus(p, 2, 4);
        driveInputs();
        runToIdle(60);
        checkOutput("t2Count", outQ.size(), 16);
        for (int k = 0; k < 16 && k < outQ.size(); k++) begin
            checkOutput("t2Data", outQ[k].data, expData(k / 4, 2, k % 4));
            checkOutput("t2Last", outQ[k].last, (k % 4 == 3));
            checkOutput("t2Cycle", outCycle[k], 1 + (k / 4) * 5 + (k % 4));
            checkOutput("t2Grant", outGrant[k], 4'b0001 << (k / 4));
        end

        // Oversize packet on port 2: 80 beats, cut after 69
        doReset();
        applyStimulus(2, 3, 80);
        driveInputs();
        runToIdle(200);
        checkOutput("t3Count", outQ.size(), 69);
        for (int k = 0; k < 69 && k < outQ.size(); k++) begin
            checkOutput("t3Data", outQ[k].data, expData(2, 3, k));
            checkOutput("t3Last", outQ[k].last, (k == 68));
            checkOutput("t3User", outQ[k].user, (k == 68));
        end
        checkOutput("t3ErrPulses", errPulses, 1);
        checkOutput("t3OvPort", ovPort, 2);
        checkOutput("t3Consumed", popCount[2], 80);
        checkOutput("t3Grant", outGrant.size() > 0 ? outGrant[0] : 4'b0, 4'b0100);

        // Back-pressure toggling on port 1
        doReset();
        applyStimulus(1, 4, 5);
        driveInputs();
        for (int i = 0; i < 12; i++) begin
            mReady = (i >= 1 && i <= 6) ? (i % 2 == 1) : 1'b1;
            stepCycle();
        end
        mReady = 1'b1;
        checkOutput("t4Count", outQ.size(), 5);
        for (int k = 0; k < 5 && k < outQ.size(); k++) begin
            checkOutput("t4Data", outQ[k].data, expData(1, 4, k));
        end
        checkOutput("t4Consumed", popCount[1], 5);
        checkOutput("t4GrantAfter", grant, 0);

        // Reset in the middle of a packet, with the pointer moved off port 0
        doReset();
        applyStimulus(0, 5, 1);
        driveInputs();
        runToIdle(10);
        outQ.delete();
        outGrant.delete();
        outCycle.delete();
        applyStimulus(0, 6, 5);
        driveInputs();
        for (int n = 0; n < 10 && outQ.size() < 2; n++) stepCycle();
        checkOutput("t5Reached", outQ.size(), 2);
        checkOutput("t5ValidBefore", mValid, 1);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("t5AsyncSReady", sReady, 0);
        checkOutput("t5AsyncMValid", mValid, 0);
        checkOutput("t5AsyncGrant", grant, 0);
        doReset();
        applyStimulus(1, 7, 2);
        applyStimulus(0, 7, 2);
        driveInputs();
        runToIdle(30);
        checkOutput("t5Count", outQ.size(), 4);
        if (outQ.size() == 4) begin
            checkOutput("t5First", outQ[0].data, expData(0, 7, 0));
            checkOutput("t5Second", outQ[2].data, expData(1, 7, 0));
        end

        // Single-beat packet on port 3
        doReset();
        applyStimulus(3, 8, 1);
        driveInputs();
        stepCycle();
        checkOutput("t7Grant", grant, 4'b1000);
        stepCycle();
        checkOutput("t7GrantAfter", grant, 0);
        checkOutput("t7Count", outQ.size(), 1);
        if (outQ.size() == 1) begin
            checkOutput("t7Data", outQ[0].data, expData(3, 8, 0));
            checkOutput("t7Last", outQ[0].last, 1);
        end

`ifdef TLP_ARB_STATS_EN
        // Packet counters: three on port 3, one truncated on port 0
        doReset();
        checkOutput("t6RstCount", pktCount, 0);
        for (int i = 0; i < 3; i++) applyStimulus(3, 9 + i, 2);
        applyStimulus(0, 12, 70);
        driveInputs();
        runToIdle(300);
        checkOutput("t6Slice0", pktCount[15:0], 1);
        checkOutput("t6Slice1", pktCount[31:16], 0);
        checkOutput("t6Slice2", pktCount[47:32], 0);
        checkOutput("t6Slice3", pktCount[63:48], 3);
        checkOutput("t6ErrPulses", errPulses, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
